systolic_array_param: RTL and testbench

Parametrised weight-stationary systolic matrix multiplier, the generalised successor of the fixed 2×2 array in the NeuroCore datapath. It computes C = A·B for an M×K block A and a K×N block B on a K×N PE grid, with input skew and output deskew generated internally. It adds a start/busy/done handshake and an optional accumulate mode. The block sits between the block-tiling controller and the result write-back path.

---
 rtl/systolic_array_param.sv | 145 ++++++++++++++
 tb/tb_systolic_array_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_param.sv
// Weight-stationary systolic multiplier: C = A*B on a ROWS x COLS PE grid,
// with internal input skew, output deskew and an optional accumulate mode.
//
// state | meaning
// IDLE  | waiting for load or start
// RUN   | streaming A through the grid, run counter t advancing
// DONE  | result valid, block_multiply_done high
`ifndef DATA_W
`define DATA_W 8
`endif

module systolic_array_param #(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int M      = 2,
    parameter int DATA_W = `DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         start,
    input  logic                         acc_mode,
    input  logic [M*ROWS*DATA_W-1:0]     block_a,
    input  logic [ROWS*COLS*DATA_W-1:0]  block_b,
    output logic                         busy,
    output logic                         block_multiply_done,
    output logic [M*COLS*DATA_W-1:0]     block_result
);
    localparam int LAST = M + ROWS + COLS - 2;
    localparam int CW   = $clog2(LAST + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state;
    logic [CW-1:0]            t;
    logic                     acc_q;
    logic [DATA_W-1:0]        a_reg    [M][ROWS];
    logic [DATA_W-1:0]        w_reg    [ROWS][COLS];
    logic [DATA_W-1:0]        sum_q    [ROWS][COLS];
    logic [DATA_W-1:0]        pass_q   [ROWS][COLS];
    logic [DATA_W-1:0]        res_buf  [M][COLS];
    logic [DATA_W-1:0]        west     [ROWS][COLS];
    logic [DATA_W-1:0]        north    [ROWS][COLS];
    logic [DATA_W-1:0]        buf_next [M][COLS];
    logic [M*COLS*DATA_W-1:0] res_next;

    // Input skew: row k sees A[m][k] when t == m + k.
    always_comb begin
        for (int k = 0; k < ROWS; k++) begin
            west[k][0] = '0;
            for (int m = 0; m < M; m++)
                if (int'(t) == m + k) west[k][0] = a_reg[m][k];
            for (int n = 1; n < COLS; n++)
                west[k][n] = pass_q[k][n-1];
        end
        for (int n = 0; n < COLS; n++) begin
            north[0][n] = '0;
            for (int k = 1; k < ROWS; k++)
                north[k][n] = sum_q[k-1][n];
        end
    end

    // Output deskew; includes the element landing on the completion edge itself.
    always_comb begin
        res_next = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < COLS; n++) begin
                buf_next[m][n] = res_buf[m][n];
                if (int'(t) == m + n + ROWS) buf_next[m][n] = sum_q[ROWS-1][n];
                res_next[(m*COLS+n)*DATA_W +: DATA_W] = acc_q ?
                    block_result[(m*COLS+n)*DATA_W +: DATA_W] + buf_next[m][n] :
                    buf_next[m][n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            t                   <= '0;
            acc_q               <= 1'b0;
            busy                <= 1'b0;
            block_multiply_done <= 1'b0;
            block_result        <= '0;
            for (int m = 0; m < M; m++) begin
                for (int k = 0; k < ROWS; k++) a_reg[m][k] <= '0;
                for (int n = 0; n < COLS; n++) res_buf[m][n] <= '0;
            end
            for (int k = 0; k < ROWS; k++) begin
                for (int n = 0; n < COLS; n++) begin
                    w_reg[k][n]  <= '0;
                    sum_q[k][n]  <= '0;
                    pass_q[k][n] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        for (int m = 0; m < M; m++)
                            for (int k = 0; k < ROWS; k++)
                                a_reg[m][k] <= block_a[(m*ROWS+k)*DATA_W +: DATA_W];
                        for (int k = 0; k < ROWS; k++)
                            for (int n = 0; n < COLS; n++)
                                w_reg[k][n] <= block_b[(k*COLS+n)*DATA_W +: DATA_W];
                        block_multiply_done <= 1'b0;
                        state               <= IDLE;
                    end else if (start) begin
                        for (int k = 0; k < ROWS; k++) begin
                            for (int n = 0; n < COLS; n++) begin
                                sum_q[k][n]  <= '0;
                                pass_q[k][n] <= '0;
                            end
                        end
                        t                   <= '0;
                        acc_q               <= acc_mode;
                        block_multiply_done <= 1'b0;
                        busy                <= 1'b1;
                        state               <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < ROWS; k++) begin
                        for (int n = 0; n < COLS; n++) begin
                            sum_q[k][n]  <= north[k][n] + west[k][n] * w_reg[k][n];
                            pass_q[k][n] <= west[k][n];
                        end
                    end
                    for (int m = 0; m < M; m++)
                        for (int n = 0; n < COLS; n++)
                            res_buf[m][n] <= buf_next[m][n];
                    if (t == CW'(LAST)) begin
                        block_result        <= res_next;
                        busy                <= 1'b0;
                        block_multiply_done <= 1'b1;
                        state               <= DONE;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_array_param.sv
// Scoreboard bench for systolic_array_param: a 2x2x2 instance for the directed
// protocol/accumulate/wrap cases and a 3x4 grid with M=5 for the non-square case.
module tb_systolic_array_param;
    logic         clk = 1'b0;
    logic         rst;
    logic         load, start, acc_mode;
    logic [31:0]  block_a, block_b;
    logic         busy, done;
    logic [31:0]  result;
    logic         big_load, big_start, big_acc;
    logic [119:0] big_a;
    logic [95:0]  big_b;
    logic         big_busy, big_done;
    logic [159:0] big_result;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0]  exp_q[$];
    logic [159:0] big_q[$];
    logic         done_prev = 1'b0;
    logic         big_done_prev = 1'b0;
    logic [31:0]  exp_d;
    logic [159:0] exp_b;

    localparam logic [31:0] A1    = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] B1    = {8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [31:0] R1    = {8'd50, 8'd43, 8'd22, 8'd19};
    localparam logic [31:0] R2    = {8'd100, 8'd86, 8'd44, 8'd38};
    localparam logic [31:0] A_OVF = {8'd0, 8'd0, 8'd200, 8'd200};
    localparam logic [31:0] B_OVF = {8'd0, 8'd2, 8'd0, 8'd2};
    localparam logic [31:0] R_OVF = {8'd0, 8'd0, 8'd0, 8'd32};

    always #5 clk = ~clk;

    systolic_array_param #(.ROWS(2), .COLS(2), .M(2), .DATA_W(8)) u_dut (
        .clk(clk), .rst(rst), .load(load), .start(start), .acc_mode(acc_mode),
        .block_a(block_a), .block_b(block_b), .busy(busy),
        .block_multiply_done(done), .block_result(result));

    systolic_array_param #(.ROWS(3), .COLS(4), .M(5), .DATA_W(8)) u_big (
        .clk(clk), .rst(rst), .load(big_load), .start(big_start), .acc_mode(big_acc),
        .block_a(big_a), .block_b(big_b), .busy(big_busy),
        .block_multiply_done(big_done), .block_result(big_result));

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_done: got result 0x%0h, expected no completion", result);
            end else begin
                exp_d = exp_q.pop_front();
                chk("result", 160'(result), 160'(exp_d));
            end
        end
        done_prev = done;
    end

    always @(negedge clk) begin
        if (big_done === 1'b1 && big_done_prev !== 1'b1) begin
            if (big_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL big_unexpected_done: got result 0x%0h, expected no completion", big_result);
            end else begin
                exp_b = big_q.pop_front();
                chk("big_result", big_result, exp_b);
            end
        end
        big_done_prev = big_done;
    end

    // Called at the negedge just after the start-sampling edge; counts busy cycles until done.
    task automatic wait_small(input string name, input int exp_busy);
        int cnt = 0;
        int guard = 0;
        while (done !== 1'b1 && guard < 60) begin
            if (busy === 1'b1) cnt++;
            guard++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, 160'(cnt), 160'(exp_busy));
        chk({name, "_busy_low_at_done"}, 160'(busy), 160'(0));
    endtask

    task automatic run_small(input string name, input logic acc, input logic [31:0] exp);
        acc_mode = acc;
        start    = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        wait_small(name, 5);
    endtask

    task automatic load_small(input logic [31:0] a, input logic [31:0] b);
        block_a = a;
        block_b = b;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int ba [5][3];
        int bb [3][4];
        logic [7:0] s;
        logic [159:0] big_exp;
        int cnt;
        int guard;

        rst = 1'b0; load = 1'b0; start = 1'b0; acc_mode = 1'b0;
        block_a = '0; block_b = '0;
        big_load = 1'b0; big_start = 1'b0; big_acc = 1'b0; big_a = '0; big_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 160'(busy), 160'(0));
        chk("reset_done", 160'(done), 160'(0));
        chk("reset_result", 160'(result), 160'(0));
        rst = 1'b1;
        @(negedge clk);

        // Basic run, then back-to-back accumulate from the first DONE cycle, then overwrite.
        load_small(A1, B1);
        run_small("basic", 1'b0, R1);
        run_small("acc", 1'b1, R2);
        run_small("overwrite", 1'b0, R1);

        // load/start pulsed during RUN are ignored; result holds during RUN.
        acc_mode = 1'b1;
        start    = 1'b1;
        exp_q.push_back(R2);
        @(negedge clk);
        block_a = A_OVF; block_b = B_OVF; load = 1'b1; start = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        chk("run_result_stable", 160'(result), 160'(R1));
        chk("run_busy", 160'(busy), 160'(1));
        wait_small("protocol", 4);

        // Simultaneous load+start in DONE: operands captured, no run, result held.
        block_a = A_OVF; block_b = B_OVF; load = 1'b1; start = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        chk("ldst_busy", 160'(busy), 160'(0));
        chk("ldst_done_clear", 160'(done), 160'(0));
        chk("ldst_result_held", 160'(result), 160'(R2));
        @(negedge clk);
        chk("ldst_still_idle", 160'(busy), 160'(0));

        // Wrap: 200*2 + 200*2 = 800 mod 256 = 32, using the operands captured above.
        run_small("wrap", 1'b0, R_OVF);

        // Reset in cycle 2 of a run clears everything at once.
        load_small(A1, B1);
        acc_mode = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 160'(busy), 160'(0));
        chk("midrst_done", 160'(done), 160'(0));
        chk("midrst_result", 160'(result), 160'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_small(A1, B1);
        run_small("after_rst", 1'b0, R1);

        // Non-square 3x4 grid, M=5, against a plain matrix-product model.
        for (int m = 0; m < 5; m++)
            for (int k = 0; k < 3; k++) begin
                ba[m][k] = ((m * 3 + k) * 37 + 11) % 256;
                big_a[(m*3+k)*8 +: 8] = 8'(ba[m][k]);
            end
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 4; n++) begin
                bb[k][n] = ((k * 4 + n) * 13 + 3) % 256;
                big_b[(k*4+n)*8 +: 8] = 8'(bb[k][n]);
            end
        big_exp = '0;
        for (int m = 0; m < 5; m++)
            for (int n = 0; n < 4; n++) begin
                s = 8'd0;
                for (int k = 0; k < 3; k++) s = s + 8'(ba[m][k] * bb[k][n]);
                big_exp[(m*4+n)*8 +: 8] = s;
            end
        big_load = 1'b1;
        @(negedge clk);
        big_load  = 1'b0;
        big_start = 1'b1;
        big_q.push_back(big_exp);
        @(negedge clk);
        big_start = 1'b0;
        cnt = 0;
        guard = 0;
        while (big_done !== 1'b1 && guard < 60) begin
            if (big_busy === 1'b1) cnt++;
            guard++;
            @(negedge clk);
        end
        chk("big_busy_cycles", 160'(cnt), 160'(11));

        repeat (3) @(negedge clk);
        chk("small_queue_drained", 160'(exp_q.size()), 160'(0));
        chk("big_queue_drained", 160'(big_q.size()), 160'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
